acl_txsched: RTL

//  Master-side ACL transmit scheduler. Each master TX slot it picks which LT_ADDR the link

---
 rtl/acl_txsched.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/acl_txsched.sv
// Master-side ACL transmit scheduler: each master TX slot selects retransmission,
// poll of an overdue slave, or round-robin new data, and issues a TX command.
module acl_txsched #(
  parameter int MAX_RETX = 4,
  parameter int PCNT_W   = 8
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              regi_isMaster,
  input  logic              connsnewmaster,
  input  logic [7:0]        regi_active_lt,
  input  logic [7:0]        regi_txpend,
  input  logic [PCNT_W-1:0] regi_tpoll,
  input  logic [7:0]        dec_flow,
  input  logic [7:0]        dec_arqn,
  input  logic              esco_resv,
  input  logic              ms_tslot_p,
  output logic [2:0]        ms_lt_addr,
  output logic              ms_txcmd_p,
  output logic              sched_poll,
  output logic              sched_retx,
  output logic              sched_flush_p
);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE} state_t;

  localparam logic [3:0] MAX_RETX_C = 4'(MAX_RETX);

  state_t            state_q, state_d;
  logic              inflight_q;
  logic [3:0]        retx_cnt_q;
  logic [2:0]        data_lt_q;
  logic [2:0]        rr_ptr_q;
  logic              poll_q, retx_q;
  logic [PCNT_W-1:0] pcnt_q [1:7];

  logic              clear;
  logic              inflight_eff;
  logic              grant, grant_poll, grant_retx, grant_data;
  logic [2:0]        grant_lt;
  logic              flush, retire;
  logic              poll_hit, data_hit;
  logic [2:0]        poll_lt, data_lt, cand;

  // Next LT_ADDR k steps after base within the 1..7 ring.
  function automatic logic [2:0] wrap_lt(input logic [2:0] base, input int k);
    int v;
    v = int'(base) + k;
    if (v > 7) v = v - 7;
    return 3'(v);
  endfunction

  assign clear = !rstz || connsnewmaster;

  always_comb begin
    state_d      = state_q;
    grant        = 1'b0;
    grant_poll   = 1'b0;
    grant_retx   = 1'b0;
    grant_data   = 1'b0;
    grant_lt     = ms_lt_addr;
    flush        = 1'b0;
    retire       = 1'b0;
    poll_hit     = 1'b0;
    poll_lt      = 3'd1;
    data_hit     = 1'b0;
    data_lt      = 3'd1;
    cand         = 3'd1;
    inflight_eff = inflight_q && regi_active_lt[data_lt_q];

    for (int i = 7; i >= 1; i--) begin
      if (regi_tpoll != '0 && regi_active_lt[3'(i)] && pcnt_q[3'(i)] >= regi_tpoll) begin
        poll_hit = 1'b1;
        poll_lt  = 3'(i);
      end
    end

    // Scan backwards so the candidate closest to rr_ptr is the one left standing.
    for (int k = 6; k >= 0; k--) begin
      cand = wrap_lt(rr_ptr_q, k);
      if (regi_active_lt[cand] && regi_txpend[cand] && dec_flow[cand]) begin
        data_hit = 1'b1;
        data_lt  = cand;
      end
    end

    case (state_q)
      IDLE: if (ms_tslot_p && regi_isMaster) state_d = ARB;
      ARB: begin
        state_d = IDLE;
        if (regi_isMaster && !esco_resv) begin
          if (inflight_eff && !dec_arqn[data_lt_q] && retx_cnt_q < MAX_RETX_C) begin
            grant      = 1'b1;
            grant_retx = 1'b1;
            grant_lt   = data_lt_q;
          end else begin
            if (inflight_eff) begin
              retire = 1'b1;
              flush  = !dec_arqn[data_lt_q];
            end
            if (poll_hit) begin
              grant      = 1'b1;
              grant_poll = 1'b1;
              grant_lt   = poll_lt;
            end else if (data_hit) begin
              grant      = 1'b1;
              grant_data = 1'b1;
              grant_lt   = data_lt;
            end
          end
          if (grant) state_d = ISSUE;
        end
      end
      ISSUE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!regi_isMaster) state_d = IDLE;
  end

  always_ff @(posedge clk_6M) begin
    if (clear) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      retx_cnt_q <= '0;
      data_lt_q  <= 3'd1;
      rr_ptr_q   <= 3'd1;
      ms_lt_addr <= 3'd1;
      poll_q     <= 1'b0;
      retx_q     <= 1'b0;
      for (int i = 1; i < 8; i++) pcnt_q[3'(i)] <= '0;
    end else begin
      state_q <= state_d;
      if (inflight_q && !regi_active_lt[data_lt_q]) begin
        inflight_q <= 1'b0;
        retx_cnt_q <= '0;
      end
      if (retire) begin
        inflight_q <= 1'b0;
        retx_cnt_q <= '0;
      end
      if (grant_retx) retx_cnt_q <= retx_cnt_q + 4'd1;
      if (grant_data) begin
        inflight_q <= 1'b1;
        retx_cnt_q <= '0;
        data_lt_q  <= grant_lt;
        rr_ptr_q   <= wrap_lt(grant_lt, 1);
      end
      if (state_d == ISSUE) begin
        ms_lt_addr <= grant_lt;
        poll_q     <= grant_poll;
        retx_q     <= grant_retx;
      end
      // Any grant restarts that link's poll interval once the command goes out.
      for (int i = 1; i < 8; i++) begin
        if (!regi_active_lt[3'(i)])
          pcnt_q[3'(i)] <= '0;
        else if (state_q == ISSUE && ms_lt_addr == 3'(i))
          pcnt_q[3'(i)] <= '0;
        else if (ms_tslot_p && regi_isMaster && pcnt_q[3'(i)] != '1)
          pcnt_q[3'(i)] <= pcnt_q[3'(i)] + 1'b1;
      end
    end
  end

  assign ms_txcmd_p    = (state_q == ISSUE) && regi_isMaster && !clear;
  assign sched_poll    = ms_txcmd_p && poll_q;
  assign sched_retx    = ms_txcmd_p && retx_q;
  assign sched_flush_p = flush && !clear;

endmodule
